// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (receiver, transmitter, FIFO).
//   UART_DATA_BITS  : default character width
//   UART_OVERSAMPLE : default sample ticks per bit period
//   rx_state_e      : receiver state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_tick_gen.sv
// ---------------------------------------------------------------------------
// uart_tick_gen
// Divides the system clock down to the oversample tick rate. The count runs
// 0..CLK_DIV-1 and o_Tick is high while the count sits at CLK_DIV-1.
// A synchronous clear restarts the count so tick phase can be aligned to an
// external event (the receiver aligns it to the start edge).
// Ports:
//   i_Clk  : system clock, rising edge
//   i_Rst  : asynchronous active-high reset
//   i_Clr  : synchronous clear of the divider count
//   o_Tick : one-Clk tick every CLK_DIV cycles
// ---------------------------------------------------------------------------
module uart_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Clr,
    output logic o_Tick
);

    localparam int            CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_count;

    // Free-running divider, restarted by clear or on reaching the last count
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_count <= '0;
        end else if (i_Clr || (r_count == CNT_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_Tick = (r_count == CNT_LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer
// UART receive front end: synchronises and oversamples the serial line,
// finds the start bit, shifts in DATA_BITS LSB-first, checks the stop bit
// and optionally a parity bit. Good characters appear on o_Rx_Data followed
// one cycle later by a single-cycle o_Data_Rdy strobe.
// Optional feature: define UART_RX_PARITY_EN to add one parity bit after the
// data bits (even parity, or odd when PARITY_ODD = 1). Without it the frame
// is start + data + stop and o_Parity_Err is tied low.
// Ports:
//   i_Clk         : system clock, rising edge
//   i_Rst         : asynchronous active-high reset
//   i_Rx          : asynchronous serial line, idle high
//   o_Rx_Data     : last good character, held until the next good one
//   o_Data_Rdy    : one-Clk pulse, o_Rx_Data valid and stable
//   o_Framing_Err : one-Clk pulse, stop bit sampled low
//   o_Parity_Err  : one-Clk pulse, parity mismatch
//   o_Busy        : high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int CLK_DIV    = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Rx,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Data_Rdy,
    output logic                 o_Framing_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Busy
);

    localparam int                OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]   OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]   OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam int                BIT_W   = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = PARITY;
`else
    localparam rx_state_e AFTER_DATA = STOP;
`endif

    rx_state_e            r_state;
    rx_state_e            w_nextState;
    logic                 r_sync1;
    logic                 r_rxs;
    logic                 r_rxsD;
    logic [OS_W-1:0]      r_osCnt;
    logic [BIT_W-1:0]     r_bitCnt;
    logic [DATA_BITS-1:0] r_shiftReg;
    logic [DATA_BITS-1:0] r_rxData;
    logic                 r_loadPend;
    logic                 r_dataRdy;
    logic                 r_framingErr;
    logic                 w_tick;
    logic                 w_startEdge;
    logic                 w_midStart;
    logic                 w_bitSample;
    logic                 w_parityBad;
    logic                 w_clrDiv;
    logic                 w_clrOs;
    logic                 w_clrBit;
    logic                 w_shift;
    logic                 w_parSample;
    logic                 w_load;
    logic                 w_framing;
    logic                 w_parityFault;

    uart_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tickGen (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Clr  (w_clrDiv),
        .o_Tick (w_tick)
    );

    // Two-flop synchroniser plus one delay stage for falling-edge detection;
    // all flops reset to the idle-high line level so reset never fakes a start
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_rxsD  <= 1'b1;
        end else begin
            r_sync1 <= i_Rx;
            r_rxs   <= r_sync1;
            r_rxsD  <= r_rxs;
        end
    end

    assign w_startEdge = r_rxsD & ~r_rxs;
    assign w_midStart  = w_tick && (r_osCnt == OS_MID);
    assign w_bitSample = w_tick && (r_osCnt == OS_LAST);

    // State register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; BREAK holds off re-arming until the line is high
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:   if (w_startEdge) w_nextState = START;
            START:  if (w_midStart)  w_nextState = r_rxs ? IDLE : DATA;
            DATA:   if (w_bitSample && (r_bitCnt == BIT_LAST)) w_nextState = AFTER_DATA;
            PARITY: if (w_bitSample) w_nextState = STOP;
            STOP:   if (w_bitSample) w_nextState = r_rxs ? IDLE : BREAK;
            BREAK:  if (r_rxs)       w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Per-state control strobes; a low stop bit outranks a parity fault
    always_comb begin
        w_clrDiv      = 1'b0;
        w_clrOs       = 1'b0;
        w_clrBit      = 1'b0;
        w_shift       = 1'b0;
        w_parSample   = 1'b0;
        w_load        = 1'b0;
        w_framing     = 1'b0;
        w_parityFault = 1'b0;
        case (r_state)
            IDLE: begin
                w_clrDiv = w_startEdge;
                w_clrOs  = w_startEdge;
            end
            START: begin
                if (w_midStart && !r_rxs) begin
                    w_clrOs  = 1'b1;
                    w_clrBit = 1'b1;
                end
            end
            DATA: begin
                w_shift = w_bitSample;
                w_clrOs = w_bitSample;
            end
            PARITY: begin
                w_parSample = w_bitSample;
                w_clrOs     = w_bitSample;
            end
            STOP: begin
                if (w_bitSample) begin
                    if (!r_rxs) begin
                        w_framing = 1'b1;
                    end else if (w_parityBad) begin
                        w_parityFault = 1'b1;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Bit timing counters and the LSB-first shift register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_osCnt    <= '0;
            r_bitCnt   <= '0;
            r_shiftReg <= '0;
        end else begin
            if (w_clrOs) begin
                r_osCnt <= '0;
            end else if (w_tick) begin
                r_osCnt <= r_osCnt + 1'b1;
            end
            if (w_clrBit) begin
                r_bitCnt <= '0;
            end else if (w_shift) begin
                r_bitCnt <= r_bitCnt + 1'b1;
            end
            if (w_shift) begin
                r_shiftReg <= {r_rxs, r_shiftReg[DATA_BITS-1:1]};
            end
        end
    end

    // Rx_Data loads one cycle ahead of Data_Rdy so the data is already stable
    // when the strobe rises; a downstream FIFO may clock on its rising edge
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_rxData     <= '0;
            r_loadPend   <= 1'b0;
            r_dataRdy    <= 1'b0;
            r_framingErr <= 1'b0;
        end else begin
            if (w_load) begin
                r_rxData <= r_shiftReg;
            end
            r_loadPend   <= w_load;
            r_dataRdy    <= r_loadPend;
            r_framingErr <= w_framing;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_parityBad;
    logic r_parityErr;

    // Latch the parity verdict in the parity slot; consumed at the stop bit
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_parityBad <= 1'b0;
            r_parityErr <= 1'b0;
        end else begin
            if (w_parSample) begin
                r_parityBad <= (r_rxs != ((^r_shiftReg) ^ PARITY_ODD[0]));
            end
            r_parityErr <= w_parityFault;
        end
    end

    assign w_parityBad  = r_parityBad;
    assign o_Parity_Err = r_parityErr;
`else
    logic w_unusedParity;

    assign w_parityBad    = 1'b0;
    assign o_Parity_Err   = 1'b0;
    assign w_unusedParity = w_parSample ^ w_parityFault ^ PARITY_ODD[0];
`endif

    assign o_Rx_Data     = r_rxData;
    assign o_Data_Rdy    = r_dataRdy;
    assign o_Framing_Err = r_framingErr;
    assign o_Busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deserializer
// Directed bench for the UART receiver with default parameters (8 data bits,
// 16x oversample, 4 Clk per tick = 64 Clk per bit). Parity cases are built
// only when UART_RX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_CLKS = 704;
    localparam int RDY_DELAY  = 676;
`else
    localparam int FRAME_CLKS = 640;
    localparam int RDY_DELAY  = 612;
`endif

    logic       clock;
    logic       reset;
    logic       rxLine;
    logic [7:0] rxData;
    logic       dataRdy;
    logic       framingErr;
    logic       parityErr;
    logic       busy;

    int         cyc = 0;
    int         startCyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    int         rdyCount = 0;
    int         rdyLong = 0;
    int         framingCnt = 0;
    int         parityCnt = 0;
    logic       prevRdy = 1'b0;
    logic [7:0] rdyData[$];
    int         rdyCyc[$];
    int         base;

    uart_rx_deserializer #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .CLK_DIV    (4),
        .PARITY_ODD (0)
    ) dut (
        .i_Clk         (clock),
        .i_Rst         (reset),
        .i_Rx          (rxLine),
        .o_Rx_Data     (rxData),
        .o_Data_Rdy    (dataRdy),
        .o_Framing_Err (framingErr),
        .o_Parity_Err  (parityErr),
        .o_Busy        (busy)
    );

    // 10-unit clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Rising-edge counter used to time-stamp strobes
    always @(posedge clock) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge away from DUT updates
    always @(negedge clock) begin
        if (dataRdy) begin
            rdyCount++;
            rdyData.push_back(rxData);
            rdyCyc.push_back(cyc);
            if (prevRdy) rdyLong++;
        end
        prevRdy = dataRdy;
        if (framingErr) framingCnt++;
        if (parityErr) parityCnt++;
    end

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drives one frame starting at the current falling edge; the line is
    // left at the stop-bit level when the task returns
    task automatic applyStimulus(input logic [7:0] data, input logic parityBit,
                                 input logic stopBit);
        rxLine   = 1'b0;
        startCyc = cyc;
        waitClocks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rxLine = data[i];
            waitClocks(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rxLine = parityBit;
        waitClocks(BIT_CLKS);
`else
        if (parityBit) rxLine = 1'b1;
`endif
        rxLine = stopBit;
        waitClocks(BIT_CLKS);
    endtask

    initial begin
        reset  = 1'b1;
        rxLine = 1'b1;
        waitClocks(3);
        checkOutput("rst_data", {24'd0, rxData}, 32'h00);
        checkOutput("rst_rdy", {31'd0, dataRdy}, 32'd0);
        checkOutput("rst_ferr", {31'd0, framingErr}, 32'd0);
        checkOutput("rst_perr", {31'd0, parityErr}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        waitClocks(10);

        // 0xA5, clean frame: data, latency and single-cycle strobe
        $display("[TB] frame 0xA5");
        applyStimulus(8'hA5, 1'b0, 1'b1);
        waitClocks(20);
        checkOutput("a5_count", rdyCount, 1);
        checkOutput("a5_data", {24'd0, rdyData[0]}, 32'hA5);
        checkOutput("a5_latency", rdyCyc[0] - startCyc, RDY_DELAY);
        checkOutput("a5_hold", {24'd0, rxData}, 32'hA5);
        checkOutput("a5_ferr", framingCnt, 0);
        checkOutput("a5_perr", parityCnt, 0);
        checkOutput("a5_width", rdyLong, 0);

        // Short low glitch: false start
        $display("[TB] glitch");
        rxLine = 1'b0;
        waitClocks(10);
        checkOutput("glitch_busy_hi", {31'd0, busy}, 32'd1);
        waitClocks(10);
        rxLine = 1'b1;
        waitClocks(80);
        checkOutput("glitch_busy_lo", {31'd0, busy}, 32'd0);
        checkOutput("glitch_rdy", rdyCount, 1);
        checkOutput("glitch_ferr", framingCnt, 0);

        // 0x3C with low stop bit, then line held low (break)
        $display("[TB] framing error");
        applyStimulus(8'h3C, 1'b0, 1'b0);
        waitClocks(200);
        checkOutput("frm_count", framingCnt, 1);
        checkOutput("frm_busy_break", {31'd0, busy}, 32'd1);
        checkOutput("frm_data_kept", {24'd0, rxData}, 32'hA5);
        rxLine = 1'b1;
        waitClocks(20);
        checkOutput("frm_busy_idle", {31'd0, busy}, 32'd0);
        checkOutput("frm_rdy", rdyCount, 1);
        checkOutput("frm_count_after", framingCnt, 1);
        checkOutput("frm_perr", parityCnt, 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones so the parity bit must be 1
        $display("[TB] parity");
        applyStimulus(8'h07, 1'b1, 1'b1);
        waitClocks(20);
        checkOutput("par_good_rdy", rdyCount, 2);
        checkOutput("par_good_data", {24'd0, rxData}, 32'h07);
        applyStimulus(8'h07, 1'b0, 1'b1);
        waitClocks(20);
        checkOutput("par_bad_perr", parityCnt, 1);
        checkOutput("par_bad_rdy", rdyCount, 2);
        checkOutput("par_bad_ferr", framingCnt, 1);
`endif

        // Four characters with no idle gap between frames
        $display("[TB] back-to-back");
        base = rdyCount;
        applyStimulus(8'h01, 1'b1, 1'b1);
        applyStimulus(8'h80, 1'b1, 1'b1);
        applyStimulus(8'hFF, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        waitClocks(20);
        checkOutput("b2b_count", rdyCount - base, 4);
        if (rdyCount - base == 4) begin
            checkOutput("b2b_data0", {24'd0, rdyData[base]}, 32'h01);
            checkOutput("b2b_data1", {24'd0, rdyData[base+1]}, 32'h80);
            checkOutput("b2b_data2", {24'd0, rdyData[base+2]}, 32'hFF);
            checkOutput("b2b_data3", {24'd0, rdyData[base+3]}, 32'h00);
            checkOutput("b2b_gap1", rdyCyc[base+1] - rdyCyc[base], FRAME_CLKS);
            checkOutput("b2b_gap2", rdyCyc[base+2] - rdyCyc[base+1], FRAME_CLKS);
            checkOutput("b2b_gap3", rdyCyc[base+3] - rdyCyc[base+2], FRAME_CLKS);
        end
        checkOutput("b2b_width", rdyLong, 0);

        // Reset in the middle of data bit 4 of 0x55, then a clean 0x96
        $display("[TB] reset mid-frame");
        base = rdyCount;
        rxLine = 1'b0;
        waitClocks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rxLine = (i % 2 == 0) ? 1'b1 : 1'b0;
            waitClocks(BIT_CLKS);
        end
        rxLine = 1'b1;
        waitClocks(BIT_CLKS / 2);
        reset = 1'b1;
        waitClocks(4);
        reset = 1'b0;
        waitClocks(BIT_CLKS * 8);
        checkOutput("rst_mid_rdy", rdyCount - base, 0);
        checkOutput("rst_mid_data", {24'd0, rxData}, 32'h00);
        checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_mid_ferr", framingCnt, 1);
        applyStimulus(8'h96, 1'b0, 1'b1);
        waitClocks(20);
        checkOutput("rst_96_count", rdyCount - base, 1);
        checkOutput("rst_96_data", {24'd0, rxData}, 32'h96);
        checkOutput("rst_96_width", rdyLong, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
